// File: rtl/resp_line_if.sv
// Byte-stream and decoded-strobe bundle between the UART receiver side
// and the response line parser.
interface resp_line_if;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        armed;
  logic [15:0] resp_value;
  logic        resp_valid;
  logic        resp_error;
  logic [1:0]  err_code;
  logic        cmd_on;
  logic        cmd_off;
  logic        busy;

  modport master (
    output rx_data, rx_data_valid, armed,
    input  resp_value, resp_valid, resp_error, err_code, cmd_on, cmd_off, busy
  );

  modport slave (
    input  rx_data, rx_data_valid, armed,
    output resp_value, resp_valid, resp_error, err_code, cmd_on, cmd_off, busy
  );
endinterface

// File: rtl/resp_line_parser.sv
// Parses "RESP:YYYY" lines and bare Y/N commands from a UART byte stream
// into registered one-cycle strobes for the authentication FSM.
module resp_line_parser #(
  parameter int TIMEOUT_CYCLES = 1_200_000
) (
  input  logic       clk,
  input  logic       rst,
  resp_line_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NOT_ARMED = 2'd0;
  localparam logic [1:0] ERR_FORMAT    = 2'd1;
  localparam logic [1:0] ERR_BADHEX    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HEX,
    S_EOL,
    S_DISCARD
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    hdr_idx_reg, hdr_idx_next;
  logic [2:0]    hex_cnt_reg, hex_cnt_next;
  logic [15:0]   acc_reg, acc_next;
  logic [CW-1:0] tmo_reg, tmo_next;
  logic [15:0]   value_reg, value_next;
  logic          valid_reg, valid_next;
  logic          error_reg, error_next;
  logic [1:0]    code_reg, code_next;
  logic          on_reg, on_next;
  logic          off_reg, off_next;

  logic          byte_in;
  logic          tmo_fire;
  logic [4:0]    nib;

  // Header character expected at hdr_idx; index 0 is the 'R' consumed in IDLE.
  function automatic logic [7:0] hdr_char(input logic [2:0] idx);
    case (idx)
      3'd1:    return 8'h45;
      3'd2:    return 8'h53;
      3'd3:    return 8'h50;
      3'd4:    return 8'h3A;
      default: return 8'h00;
    endcase
  endfunction

  // {is_hex, nibble}
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0_0000;
  endfunction

  assign byte_in  = bus.rx_data_valid;
  assign nib      = hex_decode(bus.rx_data);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_fire = !byte_in && (state_reg != S_IDLE) && (tmo_reg == TMO_LAST);

  always_comb begin
    state_next   = state_reg;
    hdr_idx_next = hdr_idx_reg;
    hex_cnt_next = hex_cnt_reg;
    acc_next     = acc_reg;
    value_next   = value_reg;
    valid_next   = 1'b0;
    error_next   = 1'b0;
    code_next    = ERR_NOT_ARMED;
    on_next      = 1'b0;
    off_next     = 1'b0;

    if (state_reg == S_IDLE || byte_in || tmo_fire)
      tmo_next = '0;
    else
      tmo_next = tmo_reg + CW'(1);

    if (byte_in) begin
      case (state_reg)
        S_IDLE: begin
          if (bus.rx_data == 8'h52) begin
            state_next   = S_HDR;
            hdr_idx_next = 3'd1;
          end else if (bus.rx_data == 8'h59 || bus.rx_data == 8'h79) begin
            on_next = 1'b1;
          end else if (bus.rx_data == 8'h4E || bus.rx_data == 8'h6E) begin
            off_next = 1'b1;
          end else if (bus.rx_data != CH_CR && bus.rx_data != CH_LF) begin
            state_next = S_DISCARD;
          end
        end
        S_HDR: begin
          if (bus.rx_data == hdr_char(hdr_idx_reg)) begin
            if (hdr_idx_reg == 3'd4) begin
              state_next   = S_HEX;
              hex_cnt_next = 3'd0;
              acc_next     = 16'h0000;
            end else begin
              hdr_idx_next = hdr_idx_reg + 3'd1;
            end
          end else begin
            error_next = 1'b1;
            code_next  = ERR_FORMAT;
            state_next = (bus.rx_data == CH_LF) ? S_IDLE : S_DISCARD;
          end
        end
        S_HEX: begin
          if (nib[4]) begin
            acc_next = {acc_reg[11:0], nib[3:0]};
            if (hex_cnt_reg == 3'd3)
              state_next = S_EOL;
            else
              hex_cnt_next = hex_cnt_reg + 3'd1;
          end else begin
            error_next = 1'b1;
            code_next  = ERR_BADHEX;
            state_next = (bus.rx_data == CH_LF) ? S_IDLE : S_DISCARD;
          end
        end
        S_EOL: begin
          if (bus.rx_data == CH_LF) begin
            state_next = S_IDLE;
            if (bus.armed) begin
              value_next = acc_reg;
              valid_next = 1'b1;
            end else begin
              error_next = 1'b1;
              code_next  = ERR_NOT_ARMED;
            end
          end else if (bus.rx_data != CH_CR) begin
            error_next = 1'b1;
            code_next  = ERR_FORMAT;
            state_next = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (bus.rx_data == CH_LF)
            state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (tmo_fire) begin
      // A stalled discard just resynchronises; only an open line reports.
      if (state_reg != S_DISCARD) begin
        error_next = 1'b1;
        code_next  = ERR_TIMEOUT;
      end
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      hdr_idx_reg <= 3'd0;
      hex_cnt_reg <= 3'd0;
      acc_reg     <= 16'h0000;
      tmo_reg     <= '0;
      value_reg   <= 16'h0000;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
      code_reg    <= 2'd0;
      on_reg      <= 1'b0;
      off_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hdr_idx_reg <= hdr_idx_next;
      hex_cnt_reg <= hex_cnt_next;
      acc_reg     <= acc_next;
      tmo_reg     <= tmo_next;
      value_reg   <= value_next;
      valid_reg   <= valid_next;
      error_reg   <= error_next;
      code_reg    <= code_next;
      on_reg      <= on_next;
      off_reg     <= off_next;
    end
  end

  assign bus.resp_value = value_reg;
  assign bus.resp_valid = valid_reg;
  assign bus.resp_error = error_reg;
  assign bus.err_code   = code_reg;
  assign bus.cmd_on     = on_reg;
  assign bus.cmd_off    = off_reg;
  assign bus.busy       = (state_reg != S_IDLE);
endmodule

// File: doc/resp_line_parser.md
# resp_line_parser

Byte-stream line parser between `uart_rx` and the challenge-response authentication FSM. It consumes received UART bytes and recognises two kinds of input:

- complete `RESP:YYYY` lines, decoded to a 16-bit value;
- single-character `Y`/`N` control commands typed outside a line.

Outputs are registered one-cycle strobes, so the auth FSM no longer buffers or parses raw ASCII. Malformed lines, stalled lines and lines that arrive while no challenge is outstanding are rejected with a coded error strobe.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_200_000 (100 ms at 12 MHz): inter-byte timeout while a line is open; legal range 2 to 2^26-1.

Ports:
- `clk` input 1: system clock (12 MHz).
- `rst` input 1: reset. Asynchronous, active-high.
- `rx_data` input 8: received byte from `uart_rx`.
- `rx_data_valid` input 1: one-cycle strobe qualifying `rx_data`.
- `armed` input 1: high while the auth FSM awaits a response; sampled on the cycle the terminating `\n` is accepted.
- `resp_value` output 16: decoded response; holds its value until the next `resp_valid`.
- `resp_valid` output 1: one-cycle strobe, a well-formed line was accepted while armed.
- `resp_error` output 1: one-cycle strobe, the line was rejected.
- `err_code` output 2: meaningful only with `resp_error`. Codes: 0 NOT_ARMED, 1 FORMAT, 2 BADHEX, 3 TIMEOUT.
- `cmd_on` output 1: one-cycle strobe for `Y`/`y` received in IDLE.
- `cmd_off` output 1: one-cycle strobe for `N`/`n` received in IDLE.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
State machine: IDLE, HDR, HEX, EOL, DISCARD. Registers: `hdr_idx[2:0]`, `hex_cnt[2:0]`, `acc[15:0]`, timeout counter of width `$clog2(TIMEOUT_CYCLES+1)`.

- **IDLE**
  - `R` (0x52): go to HDR with `hdr_idx`=1.
  - `Y`/`y`: `cmd_on` pulse.
  - `N`/`n`: `cmd_off` pulse.
  - `\r` (0x0D) and `\n` (0x0A): ignored.
  - Any other byte: go to DISCARD silently, with no error.
- **HDR**
  - Expects `E`, `S`, `P`, `:` in order, all case-sensitive.
  - When `:` matches: go to HEX with `hex_cnt`=0 and `acc`=0.
  - On mismatch: FORMAT error. Next state is IDLE if the byte was `\n`, otherwise DISCARD.
- **HEX**
  - Accepts 0-9, A-F, a-f, with `acc <= {acc[11:0], nibble}`.
  - After the 4th digit: go to EOL.
  - Any non-hex byte, including `\n`: BADHEX error. Next state is IDLE if the byte was `\n`, otherwise DISCARD.
- **EOL**
  - `\r`: ignored, any number of times.
  - `\n` with `armed`=1: `resp_value <= acc`, `resp_valid` pulse, go to IDLE.
  - `\n` with `armed`=0: NOT_ARMED error, `resp_value` unchanged, go to IDLE.
  - Any other byte, including a 5th hex digit: FORMAT error, go to DISCARD.
- **DISCARD**
  - Drops bytes until `\n`, then goes to IDLE.
  - Never emits a strobe. `Y`/`N` bytes here are not commands.
- **Timeout**
  - Applies in HDR, HEX and EOL: TIMEOUT error, go to IDLE.
  - Applies in DISCARD: go to IDLE silently.
- **Strobes:** at most one of `resp_valid`, `resp_error`, `cmd_on`, `cmd_off` is high in any cycle.

## Timing
- **Reset:** every output is 0, the state is IDLE, and `acc`, `hdr_idx`, `hex_cnt` and the counter are all 0. Reset mid-line discards the partial line with no strobe.
- **Latency:** every strobe is asserted exactly 1 cycle after the `rx_data_valid` cycle of the causing byte. `resp_value` updates on the same edge as `resp_valid`.
- **Throughput:** `rx_data_valid` may be high on consecutive cycles; every byte is processed with no drop.
- **Timeout counter behaviour:**
  - Cleared on every accepted byte and whenever the state is IDLE.
  - Increments on each cycle with no byte while not in IDLE.
  - Fires on the cycle it equals `TIMEOUT_CYCLES-1` with no byte.
- **Timeout timing:** the `resp_error` for a TIMEOUT appears `TIMEOUT_CYCLES+1` cycles after the last byte's valid cycle.
- **Byte on the expiry cycle:** a byte arriving on the would-be expiry cycle wins. It is processed normally and the counter clears.
- **`armed` sampling:** `armed` is sampled only on the `\n` cycle. Changes at any other time have no effect.

## Test plan
- **Good response:** `armed`=1; bytes `RESP:1A2F\n` sent back-to-back on consecutive cycles -> one `resp_valid`, `resp_value`=16'h1A2F one cycle after `\n`; no other strobes; `busy` back to 0.
- **Lowercase hex with CR:** `armed`=1; `RESP:a5c3\r\n` -> `resp_valid` with 16'hA5C3. Repeat with `armed`=0 -> `resp_error`, `err_code`=0, `resp_value` still 16'hA5C3.
- **Bad hex:** `RESP:12G4Y\n` -> `resp_error`, `err_code`=2, one cycle after `G`; no `cmd_on` for the `Y`. A following bare `Y` -> `cmd_on`.
- **Bad header:** `RESQ:0000\n` -> FORMAT (`err_code`=1) one cycle after `Q`. `RESP:00001\n` -> FORMAT one cycle after the 5th digit. A subsequent `N` -> `cmd_off`.
- **Timeout:** `TIMEOUT_CYCLES`=100; send `RESP:12` then go idle -> `resp_error`, `err_code`=3, exactly 101 cycles after `2`. In a second run, a byte on cycle 100 suppresses the timeout.
- **Reset mid-line:** assert `rst` asynchronously after `RESP:1A` -> all outputs 0 immediately; after release, `2F\n` yields no strobes, then `RESP:BEEF\n` -> `resp_valid`, 16'hBEEF.
